// File: rtl/kmeans_iter_ctrl.sv
// Kmeans iteration controller: assign phase streams points and collects labels, update phase walks clusters.
// Latency: 40 cycles per iteration with 1-cycle ack/done turnaround (defaults); done pulses one cycle after CHECK.
// Backpressure: waits on pt_ack / upd_done; optional watchdog under `KMEANS_CTRL_TIMEOUT_EN aborts stalled waits.
module kmeans_iter_ctrl #(
  parameter int N_POINTS = 16,
  parameter int ADDR_W   = 4,
  parameter int K        = 3,
  parameter int LABEL_W  = 2,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [ITER_W-1:0]  iter_count,
  output logic               acc_clr,
  output logic               pt_req,
  output logic [ADDR_W-1:0]  pt_addr,
  input  logic               pt_ack,
  input  logic [LABEL_W-1:0] label_in,
  output logic               upd_start,
  output logic [LABEL_W-1:0] upd_cluster,
  input  logic               upd_done,
  output logic               err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLR      = 3'd1;
  localparam logic [2:0] ST_ASSIGN   = 3'd2;
  localparam logic [2:0] ST_WAIT_LBL = 3'd3;
  localparam logic [2:0] ST_UPDATE   = 3'd4;
  localparam logic [2:0] ST_WAIT_UPD = 3'd5;
  localparam logic [2:0] ST_CHECK    = 3'd6;
  localparam logic [2:0] ST_FIN      = 3'd7;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  LAST_PT  = ADDR_W'(N_POINTS - 1);
  localparam logic [LABEL_W-1:0] LAST_CL  = LABEL_W'(K - 1);
  localparam logic [ITER_W-1:0]  ITER_LIM = ITER_W'(MAX_ITER);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]         state;
  logic [CNT_W-1:0]   change_cnt;
  logic [LABEL_W-1:0] label_mem [N_POINTS];
  logic               lbl_diff;
  logic [ITER_W-1:0]  iter_next;
  logic               in_wait;

  assign lbl_diff  = (label_in != label_mem[pt_addr]);
  assign iter_next = iter_count + ITER_W'(1);
  assign in_wait   = (state == ST_WAIT_LBL) || (state == ST_WAIT_UPD);

  assign busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign done      = (state == ST_FIN);
  assign acc_clr   = (state == ST_CLR);
  assign pt_req    = (state == ST_ASSIGN);
  assign upd_start = (state == ST_UPDATE);

`ifdef KMEANS_CTRL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_fire;

  assign wd_fire = in_wait && (wd_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) err <= 1'b0;
      if (wd_fire) err <= 1'b1;
      // any non-wait state in between restarts the count for the next wait
      if (in_wait) wd_cnt <= wd_cnt + 8'd1;
      else         wd_cnt <= '0;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pt_addr     <= '0;
      upd_cluster <= '0;
      iter_count  <= '0;
      converged   <= 1'b0;
      change_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLR;
            iter_count <= '0;
            converged  <= 1'b0;
            change_cnt <= '0;
          end
        end
        ST_CLR: begin
          pt_addr    <= '0;
          change_cnt <= '0;
          state      <= ST_ASSIGN;
        end
        ST_ASSIGN: state <= ST_WAIT_LBL;
        ST_WAIT_LBL: begin
          if (pt_ack) begin
            if (lbl_diff && (change_cnt != CNT_MAX)) change_cnt <= change_cnt + CNT_W'(1);
            if (pt_addr == LAST_PT) begin
              upd_cluster <= '0;
              state       <= ST_UPDATE;
            end else begin
              pt_addr <= pt_addr + ADDR_W'(1);
              state   <= ST_ASSIGN;
            end
          end
        end
        ST_UPDATE: state <= ST_WAIT_UPD;
        ST_WAIT_UPD: begin
          if (upd_done) begin
            if (upd_cluster == LAST_CL) begin
              state <= ST_CHECK;
            end else begin
              upd_cluster <= upd_cluster + LABEL_W'(1);
              state       <= ST_UPDATE;
            end
          end
        end
        ST_CHECK: begin
          iter_count <= iter_next;
          // labels start at 0, so a quiet first pass says nothing about convergence
          if ((change_cnt == '0) && (iter_count != '0)) begin
            converged <= 1'b1;
            state     <= ST_FIN;
          end else if (iter_next == ITER_LIM) begin
            state <= ST_FIN;
          end else begin
            state <= ST_CLR;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef KMEANS_CTRL_TIMEOUT_EN
      if (wd_fire) state <= ST_FIN;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_POINTS; i++) label_mem[i] <= '0;
    end else if ((state == ST_WAIT_LBL) && pt_ack && lbl_diff) begin
      label_mem[pt_addr] <= label_in;
    end
  end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Bench for kmeans_iter_ctrl: table of full runs plus hand-written reset, restart and watchdog sequences.
module tb_kmeans_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, converged, acc_clr, pt_req, upd_start, err;
  logic [3:0] iter_count;
  logic [3:0] pt_addr;
  logic [1:0] upd_cluster;
  logic       pt_ack, upd_done;
  logic [1:0] label_in;

  logic       resp_ack, resp_upd, drv_ack;
  logic [1:0] resp_lbl, drv_lbl;

  assign pt_ack   = resp_ack | drv_ack;
  assign label_in = drv_ack ? drv_lbl : resp_lbl;
  assign upd_done = resp_upd;

  kmeans_iter_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count), .acc_clr(acc_clr),
    .pt_req(pt_req), .pt_addr(pt_addr), .pt_ack(pt_ack), .label_in(label_in),
    .upd_start(upd_start), .upd_cluster(upd_cluster), .upd_done(upd_done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // responder controls, owned by the driver
  logic resp_en = 1'b0;
  logic no_upd = 1'b0;
  int   mode = 0;
  int   maxlat = 1;
  int   stall_addr = 16;
  int   acc_base = 0;

  int n_preq = 0, n_upd = 0, n_acc = 0, n_busy = 0;
  always @(negedge clk) begin
    n_preq = n_preq + int'(pt_req);
    n_upd  = n_upd + int'(upd_start);
    n_acc  = n_acc + int'(acc_clr);
    n_busy = n_busy + int'(busy);
  end

  typedef struct packed {
    logic       conv;
    logic [3:0] iter;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int mode; int maxlat; int mid; int conv; int iter; int preq; int upd; int busyc;
  } row_t;
  row_t rows[4];

  function automatic logic [1:0] label_for(input int a);
    int it;
    it = n_acc - acc_base;
    if (mode == 1 && a == 5) return (it % 2 == 1) ? 2'd1 : 2'd2;
    return 2'(a % 3);
  endfunction

  logic unstable = 1'b0;
  initial begin
    int a, c, lat;
    resp_ack = 1'b0; resp_upd = 1'b0; resp_lbl = 2'd0;
    forever begin
      @(posedge clk); #1;
      while (resp_en && (pt_req || upd_start)) begin
        lat = (maxlat <= 1) ? 1 : int'($urandom_range(maxlat, 1));
        if (pt_req) begin
          a = int'(pt_addr);
          if (a == stall_addr) break;
          repeat (lat) begin
            @(posedge clk); #1;
            if (int'(pt_addr) != a || pt_req) unstable = 1'b1;
          end
          resp_lbl = label_for(a);
          resp_ack = 1'b1;
          @(posedge clk); #1;
          resp_ack = 1'b0;
        end else begin
          c = int'(upd_cluster);
          if (no_upd) break;
          repeat (lat) begin
            @(posedge clk); #1;
            if (int'(upd_cluster) != c || upd_start) unstable = 1'b1;
          end
          resp_upd = 1'b1;
          @(posedge clk); #1;
          resp_upd = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // entered and left #1 after a rising edge; leaves the bench in the first cycle of the run
  task automatic pulse_start();
    acc_base = n_acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    exp_t e;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check({name, "_done_seen"}, int'(done), 1);
    check({name, "_busy_at_done"}, int'(busy), 0);
    check({name, "_sb_depth"}, sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({name, "_converged"}, int'(converged), int'(e.conv));
      check({name, "_iter_count"}, int'(iter_count), int'(e.iter));
      check({name, "_err"}, int'(err), int'(e.err));
    end
    @(posedge clk); #1;
  endtask

  function automatic int idle_word();
    return int'({busy, done, converged, acc_clr, pt_req, upd_start, err, iter_count, pt_addr, upd_cluster});
  endfunction

  initial begin
    int b_preq, b_upd, b_busy;
    string nm;
    reset = 1'b1; start = 1'b0; drv_ack = 1'b0; drv_lbl = 2'd0;

    rows[0] = '{mode: 0, maxlat: 1, mid: 0, conv: 1, iter: 2,  preq: 32,  upd: 6,  busyc: 80};
    rows[1] = '{mode: 1, maxlat: 1, mid: 0, conv: 0, iter: 15, preq: 240, upd: 45, busyc: 600};
    rows[2] = '{mode: 0, maxlat: 7, mid: 1, conv: 1, iter: 2,  preq: 32,  upd: 6,  busyc: -1};
    rows[3] = '{mode: 0, maxlat: 1, mid: 0, conv: 1, iter: 2,  preq: 32,  upd: 6,  busyc: 80};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outputs", idle_word(), 0);

    // start timing with the responder silent, then reset from WAIT_LBL
    pulse_start();
    check("acc_clr_after_start", int'({acc_clr, pt_req}), 2);
    @(posedge clk); #1;
    check("pt_req_after_clr", int'({pt_req, pt_addr}), 16);
    @(posedge clk); #1;
    check("wait_lbl_busy", int'({busy, pt_req}), 2);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_overrides_wait", idle_word(), 0);

    // mid-run reset while stalled on point 9
    resp_en = 1'b1; mode = 0; maxlat = 1; stall_addr = 9;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      if (pt_req && pt_addr == 4'd9) break;
      @(posedge clk); #1;
    end
    check("reach_pt9", int'({pt_req, pt_addr}), 16 + 9);
    @(posedge clk); #1;
    check("stall_at_pt9", int'({busy, pt_addr}), 16 + 9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_idle", idle_word(), 0);
    drv_lbl = 2'd3; drv_ack = 1'b1;
    @(posedge clk); #1;
    drv_ack = 1'b0;
    check("stray_ack_ignored", int'({busy, pt_req, pt_addr}), 0);
    @(posedge clk); #1;

    stall_addr = 16;
    sbq.push_back('{conv: 1'b1, iter: 4'd2, err: 1'b0});
    pulse_start();
    check("restart_acc_clr", int'(acc_clr), 1);
    @(posedge clk); #1;
    check("restart_pt0", int'({pt_req, pt_addr}), 16);
    wait_done("restart", 3000);

    foreach (rows[i]) begin
      nm = $sformatf("row%0d", i);
      mode = rows[i].mode; maxlat = rows[i].maxlat;
      b_preq = n_preq; b_upd = n_upd; b_busy = n_busy;
      sbq.push_back('{conv: rows[i].conv[0], iter: rows[i].iter[3:0], err: 1'b0});
      pulse_start();
      if (rows[i].mid != 0) begin
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(nm, 20000);
      check({nm, "_pt_req_count"}, n_preq - b_preq, rows[i].preq);
      check({nm, "_upd_start_count"}, n_upd - b_upd, rows[i].upd);
      if (rows[i].busyc >= 0) check({nm, "_busy_cycles"}, n_busy - b_busy, rows[i].busyc);
      check({nm, "_addr_stable"}, int'(unstable), 0);
    end

`ifdef KMEANS_CTRL_TIMEOUT_EN
    begin
      int wk;
      mode = 0; maxlat = 1; no_upd = 1'b1;
      sbq.push_back('{conv: 1'b0, iter: 4'd0, err: 1'b1});
      pulse_start();
      for (int k = 0; k < 200; k++) begin
        if (upd_start) break;
        @(posedge clk); #1;
      end
      check("wd_upd_start_seen", int'(upd_start), 1);
      wk = 0;
      for (int k = 1; k < 400; k++) begin
        @(posedge clk); #1;
        wk = k;
        if (done) break;
      end
      check("wd_fire_window", int'(wk >= 255 && wk <= 258), 1);
      check("wd_err_at_done", int'({err, done, converged}), 6);
      sbq.pop_front();
      @(posedge clk); #1;
      check("wd_err_held", int'(err), 1);
      no_upd = 1'b0;
      sbq.push_back('{conv: 1'b1, iter: 4'd2, err: 1'b0});
      pulse_start();
      check("wd_err_cleared", int'(err), 0);
      wait_done("wd_after", 3000);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
